dma_axi_r: RTL and testbench



---
 rtl/dma_axi_r_if.sv | 81 ++++++++
 rtl/dma_axi_r.sv | 98 +++++++++
 tb/tb_dma_axi_r.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/dma_axi_r_if.sv
// Native read port + AXI-4 AR/R channels of the DMA read master.
// Master modport is the DMA side; slave modport is the interconnect/requester side.
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_LOCK_W
`define AXI_LOCK_W 1
`endif
`ifndef AXI_CACHE_W
`define AXI_CACHE_W 4
`endif
`ifndef AXI_PROT_W
`define AXI_PROT_W 3
`endif
`ifndef AXI_QOS_W
`define AXI_QOS_W 4
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

interface dma_axi_r_if #(
  parameter int ADDR_W     = `AXI_ADDR_W,
  parameter int DMA_DATA_W = 32
);
  logic [`AXI_LEN_W-1:0]   dma_len;
  logic                    dma_ready;
  logic                    error;
  logic                    valid;
  logic [ADDR_W-1:0]       addr;
  logic                    ready;
  logic [DMA_DATA_W-1:0]   rdata;

  logic [`AXI_ID_W-1:0]    m_axi_arid;
  logic [ADDR_W-1:0]       m_axi_araddr;
  logic [`AXI_LEN_W-1:0]   m_axi_arlen;
  logic [`AXI_SIZE_W-1:0]  m_axi_arsize;
  logic [`AXI_BURST_W-1:0] m_axi_arburst;
  logic [`AXI_LOCK_W-1:0]  m_axi_arlock;
  logic [`AXI_CACHE_W-1:0] m_axi_arcache;
  logic [`AXI_PROT_W-1:0]  m_axi_arprot;
  logic [`AXI_QOS_W-1:0]   m_axi_arqos;
  logic                    m_axi_arvalid;
  logic                    m_axi_arready;
  logic [`AXI_ID_W-1:0]    m_axi_rid;
  logic [DMA_DATA_W-1:0]   m_axi_rdata;
  logic [`AXI_RESP_W-1:0]  m_axi_rresp;
  logic                    m_axi_rlast;
  logic                    m_axi_rvalid;
  logic                    m_axi_rready;

  modport master (
    input  dma_len, valid, addr,
    input  m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output dma_ready, error, ready, rdata,
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    output m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid,
    output m_axi_rready
  );

  modport slave (
    output dma_len, valid, addr,
    output m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  dma_ready, error, ready, rdata,
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    input  m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/dma_axi_r.sv
// AXI-4 read master: one INCR burst per native request, beats forwarded with 1-cycle latency.
// Optional DMA_AXI_R_RLAST_CHECK_EN flags rlast placement mismatches as errors.
module dma_axi_r #(
  parameter int ADDR_W     = `AXI_ADDR_W,
  parameter int DMA_DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  dma_axi_r_if.master   bus
);
  localparam int CNT_W = `AXI_LEN_W + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR_HS = 2'd1, READ = 2'd2} state_t;

  state_t                r_state, w_next;
  logic [ADDR_W-1:0]     r_addr;
  logic [`AXI_LEN_W-1:0] r_len;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_error;
  logic                  r_arvalid;
  logic                  r_ready;
  logic [DMA_DATA_W-1:0] r_rdata;

  logic w_rready, w_beat, w_last, w_beat_err, w_start;
  logic w_unused;

  assign w_start  = (r_state == IDLE) & bus.valid;
  // R channel stalls whenever the requester withdraws valid.
  assign w_rready = (r_state == READ) & bus.valid;
  assign w_beat   = w_rready & bus.m_axi_rvalid;
  assign w_last   = (r_cnt == {1'b0, r_len});

`ifdef DMA_AXI_R_RLAST_CHECK_EN
  assign w_beat_err = (bus.m_axi_rresp != '0) | (bus.m_axi_rlast != w_last);
`else
  assign w_beat_err = (bus.m_axi_rresp != '0);
`endif
  assign w_unused = &{1'b0, bus.m_axi_rid, bus.m_axi_rlast};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.valid)           w_next = ADDR_HS;
      ADDR_HS: if (bus.m_axi_arready)   w_next = READ;
      READ:    if (w_beat && w_last)    w_next = IDLE;
      default:                          w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_error   <= 1'b0;
      r_arvalid <= 1'b0;
      r_ready   <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_arvalid <= (w_next == ADDR_HS);
      r_ready   <= w_beat;
      if (w_beat) r_rdata <= bus.m_axi_rdata;
      if (w_start) begin
        r_addr  <= bus.addr;
        r_len   <= bus.dma_len;
        r_cnt   <= '0;
        r_error <= 1'b0;
      end
      // Burst length is tracked by the counter alone; rlast never terminates it.
      if (w_beat) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_beat_err) r_error <= 1'b1;
      end
    end
  end

  assign bus.dma_ready     = (r_state == IDLE);
  assign bus.error         = r_error;
  assign bus.ready         = r_ready;
  assign bus.rdata         = r_rdata;

  assign bus.m_axi_arid    = '0;
  assign bus.m_axi_araddr  = r_addr;
  assign bus.m_axi_arlen   = r_len;
  assign bus.m_axi_arsize  = `AXI_SIZE_W'($clog2(DMA_DATA_W / 8));
  assign bus.m_axi_arburst = `AXI_BURST_W'(1);
  assign bus.m_axi_arlock  = '0;
  assign bus.m_axi_arcache = `AXI_CACHE_W'(2);
  assign bus.m_axi_arprot  = `AXI_PROT_W'(2);
  assign bus.m_axi_arqos   = '0;
  assign bus.m_axi_arvalid = r_arvalid;
  assign bus.m_axi_rready  = w_rready;
endmodule

// File: tb/tb_dma_axi_r.sv
// Scoreboard bench for dma_axi_r: requester + AXI slave models push expected beats,
// a negedge monitor pops and compares every delivered beat.
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif

module tb_dma_axi_r;
  logic clk, rst;
  dma_axi_r_if #(.ADDR_W(32), .DMA_DATA_W(32)) bus();
  dma_axi_r #(.ADDR_W(32), .DMA_DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0, miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] cur_addr;
  int          cur_len;
  bit          exp_err, abort;

  int          cfg_gap, cfg_ar_delay, cfg_bad_resp, cfg_bad_last, cfg_rst_after;
  bit          cfg_drops;
  logic [31:0] cfg_data[$];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every delivered beat must match the oldest outstanding slave beat.
  always @(negedge clk) begin
    if (bus.ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL beat_unexpected: got rdata %0h expected no beat at %0t", bus.rdata, $time);
      end else begin
        chk("rdata", bus.rdata, exp_q.pop_front());
      end
    end
  end

  task automatic set_defaults();
    cfg_gap = -1; cfg_ar_delay = -1; cfg_bad_resp = -1; cfg_bad_last = -1;
    cfg_rst_after = -1; cfg_drops = 0; cfg_data.delete();
  endtask

  task automatic slave_task();
    int n, dly, gap;
    bit ok, last;
    logic [1:0]  resp;
    logic [31:0] data;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.m_axi_arvalid && n < 50 && !abort);
    if (abort) return;
    if (!bus.m_axi_arvalid) begin chk("ar_timeout", 0, 1); return; end
    chk("ar_addr_len", {bus.m_axi_araddr, bus.m_axi_arlen}, {cur_addr, 8'(cur_len)});
    chk("ar_const", {bus.m_axi_arid, bus.m_axi_arsize, bus.m_axi_arburst, bus.m_axi_arlock,
                     bus.m_axi_arcache, bus.m_axi_arprot, bus.m_axi_arqos},
                    {4'd0, 3'd2, 2'd1, 1'b0, 4'd2, 3'd2, 4'd0});
    dly = (cfg_ar_delay >= 0) ? cfg_ar_delay : int'($urandom_range(0, 3));
    repeat (dly) begin
      @(negedge clk);
      chk("ar_hold", {bus.m_axi_arvalid, bus.m_axi_araddr, bus.m_axi_rready}, {1'b1, cur_addr, 1'b0});
    end
    bus.m_axi_arready = 1'b1;
    @(posedge clk); #1;
    bus.m_axi_arready = 1'b0;
    chk("ar_drop", bus.m_axi_arvalid, 0);
    for (int i = 0; i <= cur_len; i++) begin
      gap = (cfg_gap >= 0) ? cfg_gap : int'($urandom_range(0, 2));
      repeat (gap) begin @(posedge clk); #1; end
      if (abort) break;
      data = (i < cfg_data.size()) ? cfg_data[i] : $urandom;
      resp = (i == cfg_bad_resp || (cfg_bad_resp == -2 && $urandom_range(0, 7) == 0)) ? 2'd2 : 2'd0;
      last = (i == cur_len);
      if (i == cfg_bad_last || (cfg_bad_last == -2 && $urandom_range(0, 9) == 0)) last = !last;
      if (resp != 2'd0) exp_err = 1;
`ifdef DMA_AXI_R_RLAST_CHECK_EN
      if (last != (i == cur_len)) exp_err = 1;
`endif
      bus.m_axi_rvalid = 1'b1;
      bus.m_axi_rdata  = data;
      bus.m_axi_rresp  = resp;
      bus.m_axi_rlast  = last;
      bus.m_axi_rid    = 4'($urandom);
      exp_q.push_back(data);
      ok = 0; n = 0;
      while (!ok && !abort && n < 500) begin
        @(negedge clk); ok = bus.m_axi_rready;
        @(posedge clk); #1; n++;
      end
      bus.m_axi_rvalid = 1'b0;
      if (!ok) begin
        if (!abort) chk("r_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic req_task();
    int cnt, n;
    bit w;
    bus.addr    = cur_addr;
    bus.dma_len = 8'(cur_len);
    bus.valid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("start", {bus.m_axi_arvalid, bus.dma_ready, bus.error}, {1'b1, 1'b0, 1'b0});
    cnt = 0; n = 0;
    while (n < 3000) begin
      @(negedge clk); w = bus.m_axi_rvalid && bus.m_axi_rready;
      @(posedge clk); #1; n++;
      if (w) cnt++;
      if (cfg_rst_after >= 0 && cnt == cfg_rst_after) begin
        rst = 1'b1; abort = 1;
        #1;
        chk("rst_mid", {bus.dma_ready, bus.m_axi_arvalid, bus.m_axi_rready, bus.ready, bus.error},
                       {1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        bus.valid = 1'b0;
        return;
      end
      if (cnt == cur_len + 1) begin
        bus.valid = 1'b0;
        @(negedge clk);
        chk("done", {bus.dma_ready, bus.error}, {1'b1, exp_err});
        return;
      end
      if (cfg_drops) bus.valid = ($urandom_range(0, 3) != 0);
    end
    chk("burst_timeout", 0, 1);
    abort = 1;
    bus.valid = 1'b0;
  endtask

  task automatic run_burst(logic [31:0] a, int len);
    cur_addr = a; cur_len = len; exp_err = 0; abort = 0;
    fork
      slave_task();
      req_task();
    join
    if (cfg_rst_after >= 0) begin
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
    end else begin
      @(negedge clk);
      chk("all_beats", exp_q.size(), 0);
    end
    abort = 0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    set_defaults();
  endtask

  initial begin
    rst = 1'b1;
    bus.valid = 0; bus.addr = 0; bus.dma_len = 0;
    bus.m_axi_arready = 0; bus.m_axi_rvalid = 0; bus.m_axi_rdata = 0;
    bus.m_axi_rresp = 0; bus.m_axi_rlast = 0; bus.m_axi_rid = 0;
    set_defaults();
    repeat (3) @(negedge clk);
    chk("reset_ctl", {bus.dma_ready, bus.error, bus.ready, bus.m_axi_arvalid, bus.m_axi_rready},
                     {1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("reset_data", {bus.rdata, bus.m_axi_araddr, bus.m_axi_arlen}, 72'd0);
    rst = 1'b0;
    @(negedge clk);

    cfg_data = '{32'hDEADBEEF}; cfg_ar_delay = 0;
    run_burst(32'h100, 0);
    cfg_data = '{32'h11, 32'h22, 32'h33, 32'h44}; cfg_gap = 2;
    run_burst(32'h4000, 3);
    cfg_ar_delay = 5;
    run_burst(32'h2000, 1);
    cfg_bad_resp = 2;
    run_burst(32'h3000, 3);
    run_burst(32'h3100, 2);
    cfg_bad_last = 1;
    run_burst(32'h5000, 3);
    cfg_rst_after = 2; cfg_gap = 0;
    run_burst(32'h6000, 7);
    run_burst(32'h6100, 1);
    cfg_gap = 0;
    run_burst(32'h7000, 255);
    for (int k = 0; k < 40; k++) begin
      cfg_drops = 1; cfg_bad_resp = -2; cfg_bad_last = -2;
      run_burst($urandom, int'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
